// File: rtl/song_sequencer_pkg.sv
// Shared state encodings for the song sequencer.
// States are plain logic constants so older tools and waveform scripts can decode them.
package song_sequencer_pkg;

  typedef logic [2:0] state_t;

  localparam state_t StIdle  = 3'd0;
  localparam state_t StFetch = 3'd1;
  localparam state_t StEmit  = 3'd2;
  localparam state_t StRest  = 3'd3;
  localparam state_t StPause = 3'd4;
  localparam state_t StDone  = 3'd5;

endpackage

// File: rtl/song_sequencer_if.sv
// Control, song-memory and note-player signals of the song sequencer.
// The master modport is the sequencer; the slave modport is its environment.
interface song_sequencer_if #(
  parameter int unsigned SongW = 2,
  parameter int unsigned AddrW = 7,
  parameter int unsigned NoteW = 6,
  parameter int unsigned DurW  = 9
);
  logic                   play;
  logic                   restart;
  logic                   loop_en;
  logic [SongW-1:0]       song;
  logic                   beat;
  logic [SongW+AddrW-1:0] mem_addr;
  logic [NoteW+DurW:0]    mem_data;
  logic                   note_valid;
  logic                   note_ready;
  logic [NoteW-1:0]       note_out;
  logic [DurW-1:0]        duration_out;
  logic                   song_done;
  logic                   busy;
  logic [AddrW-1:0]       position;

  modport master (
    input  play, restart, loop_en, song, beat, mem_data, note_ready,
    output mem_addr, note_valid, note_out, duration_out, song_done, busy, position
  );

  modport slave (
    output play, restart, loop_en, song, beat, mem_data, note_ready,
    input  mem_addr, note_valid, note_out, duration_out, song_done, busy, position
  );
endinterface

// File: rtl/song_rest_timer.sv
// Beat-driven down-counter that times rest entries.
// Load wins over decrement; the count saturates at zero.
module song_rest_timer #(
  parameter int unsigned DurW = 9
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            load_i,
  input  logic [DurW-1:0] load_val_i,
  input  logic            dec_i,
  output logic            zero_o
);

  logic [DurW-1:0] cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - DurW'(1);
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/song_sequencer.sv
// Walks one song's entries in song memory and hands notes to the note player.
// Rests are timed on beat pulses; supports end marker, loop, restart and song change.
module song_sequencer
  import song_sequencer_pkg::*;
#(
  parameter int unsigned SongW  = 2,
  parameter int unsigned AddrW  = 7,
  parameter int unsigned NoteW  = 6,
  parameter int unsigned DurW   = 9,
  parameter int unsigned MemLat = 1
) (
  input logic              clk,
  input logic              reset,
  song_sequencer_if.master bus
);

  localparam int unsigned EntryW  = 1 + NoteW + DurW;
  localparam int unsigned LatW    = 2;
  localparam logic [AddrW-1:0] LastPtr = {AddrW{1'b1}};

  state_t                 state_q, state_d;
  logic [SongW-1:0]       song_q, song_d;
  logic [AddrW-1:0]       ptr_q, ptr_d;
  logic [LatW-1:0]        lat_q, lat_d;
  logic [EntryW-1:0]      entry_q, entry_d;
  logic [SongW+AddrW-1:0] mem_addr_q;
  logic                   done_q, done_d;

  logic busy, rewind, abort, handshake;
  logic step, end_hit, rest_load, rest_dec, rest_zero;

  assign busy      = (state_q != StIdle) && (state_q != StDone);
  assign rewind    = bus.restart || (bus.song != song_q);
  assign abort     = busy && rewind;
  // Abort gates valid in the same cycle, so restart beats a simultaneous handshake.
  assign handshake = bus.note_valid && bus.note_ready;
  assign rest_dec  = (state_q == StRest) && bus.beat && bus.play;

  always_comb begin
    state_d   = state_q;
    song_d    = song_q;
    ptr_d     = ptr_q;
    lat_d     = lat_q;
    entry_d   = entry_q;
    done_d    = 1'b0;
    rest_load = 1'b0;
    step      = 1'b0;
    end_hit   = 1'b0;
    if (abort) begin
      song_d  = bus.song;
      ptr_d   = '0;
      lat_d   = '0;
      state_d = bus.play ? StFetch : StIdle;
    end else begin
      case (state_q)
        StIdle: begin
          if (bus.play) begin
            song_d  = bus.song;
            ptr_d   = '0;
            lat_d   = '0;
            state_d = StFetch;
          end
        end
        StFetch: begin
          // Latency counter restarts with every new address, so stale reads are never decoded.
          if (lat_q == LatW'(MemLat)) begin
            entry_d = bus.mem_data;
            if (bus.mem_data == '0) begin
              end_hit = 1'b1;
            end else if (bus.mem_data[EntryW-1]) begin
              rest_load = 1'b1;
              state_d   = StRest;
            end else begin
              state_d = StEmit;
            end
          end else begin
            lat_d = lat_q + LatW'(1);
          end
        end
        StEmit:  step = handshake;
        StRest:  step = rest_zero;
        StPause: begin
          if (bus.play) begin
            lat_d   = '0;
            state_d = StFetch;
          end
        end
        StDone: begin
          if (rewind) begin
            song_d  = bus.song;
            ptr_d   = '0;
            lat_d   = '0;
            state_d = bus.play ? StFetch : StIdle;
          end else if (!bus.play) begin
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase

      if (step) begin
        if (ptr_q == LastPtr) begin
          end_hit = 1'b1;
        end else begin
          ptr_d   = ptr_q + AddrW'(1);
          lat_d   = '0;
          state_d = bus.play ? StFetch : StPause;
        end
      end

      if (end_hit) begin
        done_d = 1'b1;
        lat_d  = '0;
        if (bus.loop_en) begin
          ptr_d   = '0;
          state_d = StFetch;
        end else begin
          state_d = StDone;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      song_q     <= '0;
      ptr_q      <= '0;
      lat_q      <= '0;
      entry_q    <= '0;
      mem_addr_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      song_q     <= song_d;
      ptr_q      <= ptr_d;
      lat_q      <= lat_d;
      entry_q    <= entry_d;
      mem_addr_q <= {song_d, ptr_d};
      done_q     <= done_d;
    end
  end

  song_rest_timer #(
    .DurW(DurW)
  ) u_rest_timer (
    .clk_i     (clk),
    .rst_i     (reset),
    .load_i    (rest_load),
    .load_val_i(bus.mem_data[DurW-1:0]),
    .dec_i     (rest_dec),
    .zero_o    (rest_zero)
  );

  assign bus.mem_addr     = mem_addr_q;
  assign bus.note_valid   = (state_q == StEmit) && !abort;
  assign bus.note_out     = entry_q[NoteW+DurW-1:DurW];
  assign bus.duration_out = entry_q[DurW-1:0];
  assign bus.song_done    = done_q;
  assign bus.busy         = busy;
  assign bus.position     = ptr_q;

endmodule

// File: tb/tb_song_sequencer.sv
// Directed bench for song_sequencer: two instances (read latency 1 and 3) share stimulus
// and a song memory; handshakes and done pulses are logged and compared to tables.
module tb_song_sequencer;

  typedef struct packed {
    logic [5:0] note;
    logic [8:0] dur;
    logic [6:0] pos;
  } rec_t;

  localparam int C4 = 40;
  localparam int E4 = 44;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic play = 1'b0, restart = 1'b0, loop_en = 1'b0, beat = 1'b0, note_ready = 1'b0;
  logic [1:0] song = 2'd0;

  logic [15:0] mem [512];
  logic [15:0] d1, d3a, d3b, d3c;

  rec_t log1[$];
  rec_t log3[$];
  int   done1, done3;
  int   checks = 0;
  int   errors = 0;
  rec_t exp_tab[9];

  always #5 clk = ~clk;

  song_sequencer_if if1 ();
  song_sequencer_if if3 ();

  assign if1.play = play;        assign if3.play = play;
  assign if1.restart = restart;  assign if3.restart = restart;
  assign if1.loop_en = loop_en;  assign if3.loop_en = loop_en;
  assign if1.song = song;        assign if3.song = song;
  assign if1.beat = beat;        assign if3.beat = beat;
  assign if1.note_ready = note_ready;
  assign if3.note_ready = note_ready;
  assign if1.mem_data = d1;
  assign if3.mem_data = d3c;

  song_sequencer #(.MemLat(1)) dut1 (.clk(clk), .reset(reset), .bus(if1.master));
  song_sequencer #(.MemLat(3)) dut3 (.clk(clk), .reset(reset), .bus(if3.master));

  always @(posedge clk) begin
    d1  <= mem[if1.mem_addr];
    d3a <= mem[if3.mem_addr];
    d3b <= d3a;
    d3c <= d3b;
  end

  // Valid&&ready seen mid-cycle means the handshake completes at the next rising edge.
  always @(negedge clk) begin
    if (reset) begin
      log1.delete();
      log3.delete();
      done1 = 0;
      done3 = 0;
    end else begin
      if (if1.note_valid && if1.note_ready)
        log1.push_back('{note: if1.note_out, dur: if1.duration_out, pos: if1.position});
      if (if3.note_valid && if3.note_ready)
        log3.push_back('{note: if3.note_out, dur: if3.duration_out, pos: if3.position});
      if (if1.song_done) done1++;
      if (if3.song_done) done3++;
    end
  end

  function automatic logic [15:0] ent(input bit r, input int n, input int d);
    return {r, 6'(n), 9'(d)};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_rec(input string name, input rec_t act, input rec_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got note %0d dur %0d pos %0d, expected note %0d dur %0d pos %0d",
               name, act.note, act.dur, act.pos, exp.note, exp.dur, exp.pos);
    end
  endtask

  task automatic pulse_beat();
    beat = 1'b1;
    tick(1);
    beat = 1'b0;
    tick(1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    play = 1'b0; restart = 1'b0; loop_en = 1'b0; beat = 1'b0; note_ready = 1'b0;
    song = 2'd0;
    tick(2);
    reset = 1'b0;
    tick(1);
  endtask

  task automatic wait_pos(input int p, input int budget);
    for (int i = 0; i < budget && if1.position != 7'(p); i++) tick(1);
    check("wait_position", if1.position, p);
  endtask

  task automatic wait_valid(input int budget);
    for (int i = 0; i < budget && !if1.note_valid; i++) tick(1);
    check("wait_valid", if1.note_valid, 1);
  endtask

  task automatic wait_log(input int n, input int budget);
    for (int i = 0; i < budget && log1.size() < n; i++) tick(1);
    check("wait_log", log1.size(), n);
  endtask

  initial begin
    int   bad1, bad3;
    logic stable;
    rec_t e;

    for (int i = 0; i < 512; i++) mem[i] = '0;
    mem[0] = ent(0, C4, 4);  mem[1] = ent(1, 0, 2);  mem[2] = ent(0, E4, 3);
    mem[128] = ent(0, 10, 1); mem[129] = ent(0, 11, 2); mem[130] = ent(0, 12, 3);
    mem[256] = ent(0, 20, 5); mem[257] = ent(0, 21, 6);
    for (int p = 0; p < 128; p++) mem[384 + p] = ent(0, p % 64, p + 1);

    exp_tab[0] = '{6'(C4), 9'd4, 7'd0};
    exp_tab[1] = '{6'(E4), 9'd3, 7'd2};
    for (int k = 0; k < 6; k++) exp_tab[2 + k] = '{6'(10 + k % 3), 9'(1 + k % 3), 7'(k % 3)};
    exp_tab[8] = '{6'd20, 9'd5, 7'd0};

    // Reset values
    tick(2);
    check("rst_busy", if1.busy, 0);
    check("rst_valid", if1.note_valid, 0);
    check("rst_addr", if1.mem_addr, 0);
    check("rst_position", if1.position, 0);
    check("rst_done", if1.song_done, 0);
    check("rst_note", if1.note_out, 0);
    do_reset();

    // Basic song: note, 2-beat rest, note, end marker
    song = 2'd0; note_ready = 1'b1; play = 1'b1;
    wait_pos(1, 20);
    tick(4);
    check("t1_in_rest_pos", if1.position, 1);
    check("t1_in_rest_notes", log1.size(), 1);
    pulse_beat();
    tick(3);
    check("t1_rest_one_beat", if1.position, 1);
    pulse_beat();
    check("t1_rest_two_beats", if1.position, 2);
    for (int i = 0; i < 30 && if1.busy; i++) tick(1);
    tick(10);
    check("t1_busy", if1.busy, 0);
    check("t1_done_once", done1, 1);
    check("t1_end_pos", if1.position, 3);
    check("t1_notes", log1.size(), 2);
    for (int i = 0; i < 2 && i < log1.size(); i++) check_rec("t1_note", log1[i], exp_tab[i]);

    // Back-pressure in EMIT
    do_reset();
    song = 2'd0; play = 1'b1;
    wait_valid(20);
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (!(if1.note_valid && if1.note_out == 6'(C4) && if1.duration_out == 9'd4 &&
            if1.position == 7'd0)) stable = 1'b0;
      tick(1);
    end
    check("t2_hold_stable", stable, 1);
    check("t2_hold_valid", if1.note_valid, 1);
    note_ready = 1'b1;
    tick(1);
    check("t2_accept_pos", if1.position, 1);

    // play low freezes a rest
    do_reset();
    song = 2'd0; note_ready = 1'b1; play = 1'b1;
    wait_pos(1, 20);
    tick(4);
    play = 1'b0;
    for (int i = 0; i < 5; i++) pulse_beat();
    check("t3_frozen_pos", if1.position, 1);
    play = 1'b1;
    tick(2);
    check("t3_resume_pos", if1.position, 1);
    pulse_beat();
    tick(3);
    check("t3_one_left", if1.position, 1);
    pulse_beat();
    check("t3_rest_over", if1.position, 2);

    // Loop mode over a 3-note song
    do_reset();
    song = 2'd1; loop_en = 1'b1; note_ready = 1'b1; play = 1'b1;
    for (int i = 0; i < 300 && done1 < 2; i++) tick(1);
    check("t4_done_twice", done1, 2);
    check("t4_wrap_pos", if1.position, 0);
    check("t4_busy", if1.busy, 1);
    check("t4_notes", log1.size(), 6);
    for (int i = 0; i < 6 && i < log1.size(); i++) check_rec("t4_note", log1[i], exp_tab[2 + i]);
    tick(3);
    reset = 1'b1;
    #1;
    check("t4_async_busy", if1.busy, 0);
    check("t4_async_pos", if1.position, 0);
    check("t4_async_done", if1.song_done, 0);
    tick(2);
    reset = 1'b0;
    tick(1);

    // Song change while a note is waiting
    do_reset();
    song = 2'd1; play = 1'b1;
    wait_valid(20);
    song = 2'd2;
    #1;
    check("t5_valid_drop", if1.note_valid, 0);
    tick(1);
    check("t5_new_addr", if1.mem_addr, 256);
    check("t5_no_old_note", log1.size(), 0);
    note_ready = 1'b1;
    wait_log(1, 20);
    if (log1.size() > 0) check_rec("t5_first_note", log1[0], exp_tab[8]);

    // Restart coinciding with ready
    do_reset();
    song = 2'd0; play = 1'b1;
    wait_valid(20);
    note_ready = 1'b1; restart = 1'b1;
    #1;
    check("rs_valid_drop", if1.note_valid, 0);
    tick(1);
    restart = 1'b0;
    check("rs_pos", if1.position, 0);
    check("rs_no_note", log1.size(), 0);
    wait_log(1, 20);
    if (log1.size() > 0) check_rec("rs_first_note", log1[0], exp_tab[0]);

    // Full 128-entry song without end marker, both read latencies
    do_reset();
    song = 2'd3; note_ready = 1'b1; play = 1'b1;
    for (int i = 0; i < 2000 && !(done1 >= 1 && done3 >= 1); i++) tick(1);
    tick(3);
    check("t6_done1", done1, 1);
    check("t6_done3", done3, 1);
    check("t6_busy1", if1.busy, 0);
    check("t6_busy3", if3.busy, 0);
    check("t6_pos1", if1.position, 127);
    check("t6_pos3", if3.position, 127);
    check("t6_notes1", log1.size(), 128);
    check("t6_notes3", log3.size(), 128);
    bad1 = 0;
    bad3 = 0;
    for (int i = 0; i < 128; i++) begin
      e = '{6'(i % 64), 9'(i + 1), 7'(i)};
      if (i >= log1.size() || log1[i] !== e) bad1++;
      if (i >= log3.size() || log3[i] !== e) bad3++;
    end
    check("t6_seq1_bad", bad1, 0);
    check("t6_seq3_bad", bad3, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
